// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle controller: opcode, funct,
// ALU control and FSM state encodings, plus the ALU-op selector type.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_EXI  = 4'd3,
        S_MADR = 4'd4,
        S_MRD  = 4'd5,
        S_MWR  = 4'd6,
        S_WBR  = 4'd7,
        S_WBI  = 4'd8,
        S_WBL  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_LUI  = 4'd12
    } state_t;

    // What the FSM asks of the ALU decoder in a given state.
    typedef enum logic [2:0] {
        AOP_NONE,
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT,
        AOP_IMM
    } alu_op_t;

endpackage

// File: rtl/multi_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master: controller (drives strobes/selects); slave: datapath/memory.
interface multi_ctrl_if;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_we;
    logic        iord;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_we;
    logic [1:0]  mem2reg;
    logic        reg_dst;
    logic        reg_we;
    logic        alu_srca;
    logic [1:0]  alu_srcb;
    logic [2:0]  alu_ctrl;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_we, iord, mem_rd, mem_wr, ir_we,
        output mem2reg, reg_dst, reg_we,
        output alu_srca, alu_srcb, alu_ctrl,
        output pc_src, state, illegal, instr_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_we, iord, mem_rd, mem_wr, ir_we,
        input  mem2reg, reg_dst, reg_we,
        input  alu_srca, alu_srcb, alu_ctrl,
        input  pc_src, state, illegal, instr_cnt
    );

endinterface

// File: rtl/multi_ctrl_alu_dec.sv
// ALU control decoder: maps the FSM's ALU request plus op/funct to
// alu_ctrl_o. Ports: aop_i, op_i, funct_i -> alu_ctrl_o, funct_ok_o.
module alu_dec
    import mc_pkg::*;
(
    input  alu_op_t    aop_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_ok_o
);

    always_comb begin
        alu_ctrl_o = ALU_AND;
        funct_ok_o = 1'b1;
        unique case (aop_i)
            AOP_ADD: alu_ctrl_o = ALU_ADD;
            AOP_SUB: alu_ctrl_o = ALU_SUB;
            AOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_ok_o = 1'b0;
                endcase
            end
            AOP_IMM: begin
                case (op_i)
                    OP_ANDI: alu_ctrl_o = ALU_AND;
                    OP_ORI:  alu_ctrl_o = ALU_OR;
                    OP_SLTI: alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-style controller FSM with retired-instruction count.
// Ports: clk, rst (sync, active-high), bus (multi_ctrl_if.master).
module multi_ctrl
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    multi_ctrl_if.master       bus
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    alu_op_t     aop;
    logic        funct_ok;
    logic        retire;

    logic        pc_we_c, iord_c, mem_rd_c, mem_wr_c;
    logic        ir_we_c, reg_dst_c, reg_we_c;
    logic        alu_srca_c, illegal_c;
    logic [1:0]  mem2reg_c, alu_srcb_c, pc_src_c;
    logic [2:0]  alu_ctrl_c;

    alu_dec u_alu_dec (
        .aop_i      (aop),
        .op_i       (bus.op),
        .funct_i    (bus.funct),
        .alu_ctrl_o (alu_ctrl_c),
        .funct_ok_o (funct_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wraps naturally at 2^32.
    assign cnt_d = retire ? cnt_q + 32'd1 : cnt_q;

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        aop        = AOP_NONE;
        pc_we_c    = 1'b0;
        iord_c     = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        ir_we_c    = 1'b0;
        mem2reg_c  = 2'b00;
        reg_dst_c  = 1'b0;
        reg_we_c   = 1'b0;
        alu_srca_c = 1'b0;
        alu_srcb_c = 2'b00;
        pc_src_c   = 2'b00;
        illegal_c  = 1'b0;
        case (state_q)
            S_IF: begin
                mem_rd_c   = 1'b1;
                alu_srcb_c = 2'b01;
                aop        = AOP_ADD;
                ir_we_c    = bus.mem_ready;
                pc_we_c    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_ID;
            end
            S_ID: begin
                alu_srcb_c = 2'b11;
                aop        = AOP_ADD;
                case (bus.op)
                    OP_R:           state_d = S_EXR;
                    OP_LW, OP_SW:   state_d = S_MADR;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_JMP;
                    OP_LUI:         state_d = S_LUI;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI: state_d = S_EXI;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_IF;
                    end
                endcase
            end
            S_EXR: begin
                alu_srca_c = 1'b1;
                aop        = AOP_FUNCT;
                if (funct_ok) begin
                    state_d = S_WBR;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EXI: begin
                alu_srca_c = 1'b1;
                alu_srcb_c = 2'b10;
                aop        = AOP_IMM;
                state_d    = S_WBI;
            end
            S_MADR: begin
                alu_srca_c = 1'b1;
                alu_srcb_c = 2'b10;
                aop        = AOP_ADD;
                state_d    = (bus.op == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                iord_c   = 1'b1;
                mem_rd_c = 1'b1;
                if (bus.mem_ready) state_d = S_WBL;
            end
            S_MWR: begin
                iord_c   = 1'b1;
                mem_wr_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
            end
            S_WBR: begin
                reg_we_c  = 1'b1;
                reg_dst_c = 1'b1;
                state_d   = S_IF;
                retire    = 1'b1;
            end
            S_WBI: begin
                reg_we_c = 1'b1;
                state_d  = S_IF;
                retire   = 1'b1;
            end
            S_WBL: begin
                reg_we_c  = 1'b1;
                mem2reg_c = 2'b01;
                state_d   = S_IF;
                retire    = 1'b1;
            end
            S_BR: begin
                alu_srca_c = 1'b1;
                aop        = AOP_SUB;
                pc_src_c   = 2'b01;
                pc_we_c    = (bus.op == OP_BNE) ? ~bus.zero
                                                : bus.zero;
                state_d    = S_IF;
                retire     = 1'b1;
            end
            S_JMP: begin
                pc_src_c = 2'b10;
                pc_we_c  = 1'b1;
                state_d  = S_IF;
                retire   = 1'b1;
            end
            S_LUI: begin
                reg_we_c  = 1'b1;
                mem2reg_c = 2'b10;
                state_d   = S_IF;
                retire    = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Everything is held quiet while rst is high, even when the
    // state register already reads IF.
    assign bus.pc_we     = ~rst & pc_we_c;
    assign bus.iord      = ~rst & iord_c;
    assign bus.mem_rd    = ~rst & mem_rd_c;
    assign bus.mem_wr    = ~rst & mem_wr_c;
    assign bus.ir_we     = ~rst & ir_we_c;
    assign bus.mem2reg   = rst ? 2'b00 : mem2reg_c;
    assign bus.reg_dst   = ~rst & reg_dst_c;
    assign bus.reg_we    = ~rst & reg_we_c;
    assign bus.alu_srca  = ~rst & alu_srca_c;
    assign bus.alu_srcb  = rst ? 2'b00 : alu_srcb_c;
    assign bus.alu_ctrl  = rst ? 3'b000 : alu_ctrl_c;
    assign bus.pc_src    = rst ? 2'b00 : pc_src_c;
    assign bus.illegal   = ~rst & illegal_c;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// Directed self-checking bench for multi_ctrl.
// Drives the control bundle via multi_ctrl_if and checks each cycle.
module tb_multi_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   ncmp  = 0;
    int   nfail = 0;
    int   wecnt;

    always #5 clk = ~clk;

    multi_ctrl_if bus ();

    multi_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.op        = 6'b000000;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        nxt();
        nxt();
        chk("rst_state", bus.state, 0);
        chk("rst_cnt", bus.instr_cnt, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_pc_we", bus.pc_we, 0);
        chk("rst_ir_we", bus.ir_we, 0);

        // Test 1: lui
        bus.op = 6'b001111;
        rst    = 1'b0;
        #1;
        chk("if_state", bus.state, 0);
        chk("if_mem_rd", bus.mem_rd, 1);
        chk("if_ir_we", bus.ir_we, 1);
        chk("if_pc_we", bus.pc_we, 1);
        chk("if_srcb", bus.alu_srcb, 2'b01);
        chk("if_alu", bus.alu_ctrl, 3'b010);
        nxt();
        chk("lui_id", bus.state, 1);
        chk("id_srcb", bus.alu_srcb, 2'b11);
        chk("id_mem_rd", bus.mem_rd, 0);
        nxt();
        chk("lui_st", bus.state, 12);
        chk("lui_we", bus.reg_we, 1);
        chk("lui_m2r", bus.mem2reg, 2'b10);
        nxt();
        chk("lui_back", bus.state, 0);
        chk("lui_cnt", bus.instr_cnt, 1);

        // Test 2: lw with two wait cycles in MRD
        bus.op = 6'b100011;
        wecnt  = 0;
        wecnt += int'(bus.reg_we);
        nxt();
        chk("lw_id", bus.state, 1);
        wecnt += int'(bus.reg_we);
        nxt();
        chk("lw_madr", bus.state, 4);
        chk("madr_srcb", bus.alu_srcb, 2'b10);
        chk("madr_alu", bus.alu_ctrl, 3'b010);
        wecnt += int'(bus.reg_we);
        nxt();
        bus.mem_ready = 1'b0;
        #1;
        chk("lw_mrd1", bus.state, 5);
        chk("mrd_iord", bus.iord, 1);
        chk("mrd_rd", bus.mem_rd, 1);
        wecnt += int'(bus.reg_we);
        nxt();
        chk("lw_mrd2", bus.state, 5);
        wecnt += int'(bus.reg_we);
        nxt();
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mrd3", bus.state, 5);
        wecnt += int'(bus.reg_we);
        nxt();
        chk("lw_wbl", bus.state, 9);
        chk("wbl_m2r", bus.mem2reg, 2'b01);
        wecnt += int'(bus.reg_we);
        nxt();
        chk("lw_back", bus.state, 0);
        chk("lw_we_once", wecnt, 1);
        chk("lw_cnt", bus.instr_cnt, 2);

        // Test 3: beq/bne with zero
        bus.op   = 6'b000100;
        bus.zero = 1'b1;
        nxt();
        nxt();
        chk("beq_br", bus.state, 10);
        chk("beq_pc_we", bus.pc_we, 1);
        chk("br_src", bus.pc_src, 2'b01);
        chk("br_alu", bus.alu_ctrl, 3'b110);
        nxt();
        chk("beq_cnt", bus.instr_cnt, 3);
        bus.op = 6'b000101;
        nxt();
        nxt();
        chk("bne_br", bus.state, 10);
        chk("bne_z1_pc_we", bus.pc_we, 0);
        bus.zero = 1'b0;
        #1;
        chk("bne_z0_pc_we", bus.pc_we, 1);
        nxt();
        chk("bne_cnt", bus.instr_cnt, 4);

        // Test 4: illegal opcode
        bus.op = 6'b111111;
        nxt();
        chk("ill_id", bus.state, 1);
        chk("ill_pulse", bus.illegal, 1);
        chk("ill_we", bus.reg_we, 0);
        nxt();
        chk("ill_back", bus.state, 0);
        chk("ill_clear", bus.illegal, 0);
        chk("ill_cnt", bus.instr_cnt, 4);

        // Undefined funct, then R-type add, then ori
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        nxt();
        nxt();
        chk("badf_exr", bus.state, 2);
        chk("badf_ill", bus.illegal, 1);
        nxt();
        chk("badf_back", bus.state, 0);
        chk("badf_cnt", bus.instr_cnt, 4);
        bus.funct = 6'b100101;
        nxt();
        nxt();
        chk("or_alu", bus.alu_ctrl, 3'b001);
        chk("exr_srca", bus.alu_srca, 1);
        nxt();
        chk("wbr_st", bus.state, 7);
        chk("wbr_dst", bus.reg_dst, 1);
        chk("wbr_we", bus.reg_we, 1);
        nxt();
        chk("r_cnt", bus.instr_cnt, 5);
        bus.op = 6'b001010;
        nxt();
        nxt();
        chk("slti_exi", bus.state, 3);
        chk("slti_alu", bus.alu_ctrl, 3'b111);
        nxt();
        chk("wbi_st", bus.state, 8);
        chk("wbi_dst", bus.reg_dst, 0);
        nxt();
        chk("i_cnt", bus.instr_cnt, 6);

        // Test 5: reset in MWR during a memory wait
        bus.op = 6'b101011;
        nxt();
        nxt();
        nxt();
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_mwr", bus.state, 6);
        chk("mwr_wr", bus.mem_wr, 1);
        nxt();
        rst = 1'b1;
        #1;
        chk("mwr_rst_wr", bus.mem_wr, 0);
        nxt();
        rst = 1'b0;
        #1;
        chk("sw_rst_st", bus.state, 0);
        chk("sw_rst_wr", bus.mem_wr, 0);
        chk("sw_rst_cnt", bus.instr_cnt, 0);
        chk("stall_ir_we", bus.ir_we, 0);

        // Test 6: counter wrap
        force dut.cnt_d = 32'hFFFF_FFFF;
        nxt();
        release dut.cnt_d;
        #1;
        chk("preload", bus.instr_cnt, 32'hFFFF_FFFF);
        bus.op        = 6'b000010;
        bus.mem_ready = 1'b1;
        nxt();
        nxt();
        chk("j_st", bus.state, 11);
        chk("j_pc_we", bus.pc_we, 1);
        chk("j_src", bus.pc_src, 2'b10);
        nxt();
        chk("j_back", bus.state, 0);
        chk("wrap_cnt", bus.instr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 op  input  6  instruction opcode, IR[31:26], valid from ID onward.
REQ-004 funct  input  6  IR[5:0], decoded only when op=000000.
REQ-005 zero  input  1  ALU zero flag, sampled in BR.
REQ-006 mem_ready  input  1  memory handshake: access completes in any cycle it is 1.
REQ-007 pc_we  output  1  PC write enable, final: unconditional or branch-qualified.
REQ-008 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 mem_rd, mem_wr  output  1 each  memory read / write strobes.
REQ-010 ir_we  output  1  instruction register load.
REQ-011 mem2reg  output  2  register write-data select: 00=ALUOut, 01=MDR, 10=upper-immediate value {imm,16'h0}.
REQ-012 reg_dst  output  1  destination register: 0=rt, 1=rd.
REQ-013 reg_we  output  1  register file write enable.
REQ-014 alu_srca  output  1  ALU A select: 0=PC, 1=A.
REQ-015 alu_srcb  output  2  ALU B select: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-016 alu_ctrl  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-017 pc_src  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-018 state  output  4  current state code, for debug.
REQ-019 illegal  output  1  one-cycle pulse on an undefined opcode/funct.
REQ-020 instr_cnt  output  32  count of retired instructions.

Function
REQ-021 Opcodes decoded: R 000000 (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100, ori 001101, slti 001010, lui 001111.
REQ-022 States: IF=0, ID=1, EXR=2, EXI=3, MADR=4, MRD=5, MWR=6, WBR=7, WBI=8, WBL=9, BR=10, JMP=11, LUI=12; codes 13-15 go to IF next cycle.
REQ-023 IF: mem_rd=1, iord=0, alu_srca=0, alu_srcb=01, alu_ctrl=add, pc_src=00; ir_we=pc_we=mem_ready; stay in IF while mem_ready=0.
REQ-024 ID: alu_srca=0, alu_srcb=11, alu_ctrl=add (branch target). Next state: R->EXR; lw/sw->MADR; beq/bne->BR; j->JMP; lui->LUI; addi/andi/ori/slti->EXI; otherwise illegal=1, then IF.
REQ-025 EXR: alu_srca=1, alu_srcb=00, alu_ctrl from funct, then WBR. Undefined funct: illegal=1, then IF, no write.
REQ-026 EXI: alu_srca=1, alu_srcb=10; alu_ctrl add/and/or/slt for addi/andi/ori/slti; then WBI.
REQ-027 MADR: alu_srca=1, alu_srcb=10, add; lw->MRD, sw->MWR.
REQ-028 MRD: iord=1, mem_rd=1; hold until mem_ready; then WBL. MWR: iord=1, mem_wr=1; hold until mem_ready; then IF.
REQ-029 WBR: reg_we=1, reg_dst=1, mem2reg=00. WBI: reg_we=1, reg_dst=0, mem2reg=00. WBL: reg_we=1, reg_dst=0, mem2reg=01. All three go to IF.
REQ-030 BR: alu_srca=1, alu_srcb=00, sub, pc_src=01; pc_we=zero for beq, ~zero for bne; then IF.
REQ-031 JMP: pc_src=10, pc_we=1, then IF. LUI: reg_we=1, reg_dst=0, mem2reg=10, then IF.
REQ-032 Latency, mem_ready=1 throughout: lw 5 cycles; R/I-ALU/sw 4 cycles; beq/bne/j/lui 3 cycles. Each mem_ready=0 cycle adds one cycle.
REQ-033 All outputs not listed for a state are 0.
REQ-034 All outputs are Moore, except ir_we and pc_we (qualified by mem_ready/zero) and illegal.
REQ-035 instr_cnt increments by 1 on the last cycle of each legal instruction (the cycle whose next state is IF); it wraps at 2^32-1 to 0.

Reset
REQ-036 rst=1 at a clock edge forces state=IF and instr_cnt=0, including mid-instruction; a pending memory wait is abandoned.
REQ-037 During and after reset, all strobes are 0 until the first IF cycle; the decoded IF outputs then apply.

Structure
REQ-038 Opcode, funct, state and alu_ctrl encodings are constants in shared package mc_pkg.
REQ-039 The funct/opcode to alu_ctrl mapping is sub-module alu_dec; the FSM stays in multi_ctrl.

Verification
REQ-040 Test 1: rst, then op=001111, mem_ready=1 -> states 0,1,12; reg_we=1 and mem2reg=10 in cycle 3; instr_cnt=1.
REQ-041 Test 2: lw with mem_ready=0 for 2 cycles in MRD -> states 0,1,4,5,5,5,9; single reg_we with mem2reg=01.
REQ-042 Test 3: beq with zero=1 -> pc_we=1 in BR; bne with zero=1 -> pc_we=0 in BR.
REQ-043 Test 4: op=111111 -> illegal pulses in ID; no reg_we; instr_cnt unchanged; next state IF.
REQ-044 Test 5: rst asserted in MWR while mem_ready=0 -> state=0 next cycle, mem_wr=0, instr_cnt=0.
REQ-045 Test 6: instr_cnt preloaded (forced) to 32'hFFFFFFFF, then one j -> instr_cnt=0.
